rf_wb_tracer: RTL and testbench

Simulation-side commit tracer and test-termination detector that sits beside the core, register file and data memory in the RISC-V test bench. It snoops the register-file write port and the data-memory port, records every architectural register write into a parametrised circular trace buffer, and decides PASS/FAIL/TIMEOUT from a store to a tohost address. It replaces the fixed-time `$finish` and per-cycle register dumps with a drainable trace and a definite end-of-test verdict.

---
 rtl/rf_wb_tracer.sv | 147 ++++++++++++++
 tb/tb_rf_wb_tracer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_tracer.sv
// Commit tracer for the RISC-V bench: captures register-file writes into a
// circular trace buffer and latches a PASS/FAIL/TIMEOUT verdict from tohost.
module rf_wb_tracer #(
   parameter int          DWIDTH      = 32,
   parameter int          AWIDTH      = 5,
   parameter int          DEPTH       = 16,
   parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FF0,
   parameter int          MAX_CYCLES  = 100000
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   input  logic                        RF_WE,
   input  logic [AWIDTH-1:0]           RF_WA,
   input  logic [DWIDTH-1:0]           RF_WD,
   input  logic                        D_MEM_CSN,
   input  logic                        D_MEM_WEN,
   input  logic [31:0]                 D_MEM_ADDR,
   input  logic [DWIDTH-1:0]           D_MEM_DI,
   input  logic                        RD_EN,
   output logic                        RD_VALID,
   output logic [AWIDTH+DWIDTH-1:0]    RD_DATA,
   output logic [$clog2(DEPTH):0]      COUNT,
   output logic                        OVERFLOW,
   output logic                        DONE,
   output logic                        PASS,
   output logic                        FAIL,
   output logic                        TIMEOUT,
   output logic [DWIDTH-1:0]           FAIL_CODE,
   output logic [31:0]                 CYCLE_CNT,
   output logic [1:0]                  DBG_STATE
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AWIDTH + DWIDTH;

   // Trace read side is a one-deep valid/data register: RD_EN sampled with
   // COUNT>0 at an edge makes RD_VALID/RD_DATA valid for the following cycle.
   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_PASS    = 2'd1,
      S_FAIL    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] fail_code_q, fail_code_d;
   logic [31:0]       cycle_q;
   logic [EW-1:0]     mem [DEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [CW-1:0]     count_q;
   logic              overflow_q;
   logic              rd_valid_q;
   logic [EW-1:0]     rd_data_q;

   logic run, tohost_st, push_req, full, empty, do_push, do_pop;

   assign run       = (state_q == S_RUN);
   assign tohost_st = !D_MEM_CSN && !D_MEM_WEN && (D_MEM_ADDR == TOHOST_ADDR);
   assign push_req  = run && RF_WE && (RF_WA != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign do_pop    = RD_EN && !empty;
   assign do_push   = push_req && (!full || do_pop);

   always_comb begin
      state_d     = state_q;
      fail_code_d = fail_code_q;
      case (state_q)
         S_RUN: begin
            // A tohost store outranks a timeout landing on the same edge.
            if (tohost_st) begin
               if (D_MEM_DI == DWIDTH'(1)) begin
                  state_d = S_PASS;
               end else begin
                  state_d     = S_FAIL;
                  fail_code_d = D_MEM_DI >> 1;
               end
            end else if (cycle_q == 32'(MAX_CYCLES - 1)) begin
               state_d = S_TIMEOUT;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= S_RUN;
         fail_code_q <= '0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         fail_code_q <= fail_code_d;
         if (run && (cycle_q != '1)) begin
            cycle_q <= cycle_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wptr_q] <= {RF_WA, RF_WD};
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= do_pop;
         if (do_pop) begin
            rd_data_q <= mem[rptr_q];
            rptr_q    <= rptr_q + PW'(1);
         end
         if (do_push) begin
            wptr_q <= wptr_q + PW'(1);
         end
         if (push_req && !do_push) begin
            overflow_q <= 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign RD_VALID  = rd_valid_q;
   assign RD_DATA   = rd_data_q;
   assign COUNT     = count_q;
   assign OVERFLOW  = overflow_q;
   assign DONE      = !run;
   assign PASS      = (state_q == S_PASS);
   assign FAIL      = (state_q == S_FAIL);
   assign TIMEOUT   = (state_q == S_TIMEOUT);
   assign FAIL_CODE = fail_code_q;
   assign CYCLE_CNT = cycle_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_rf_wb_tracer.sv
// Bench for rf_wb_tracer: directed scenarios plus randomized traffic, checked
// against a queue-based trace model and a simple verdict/cycle model.
module tb_rf_wb_tracer;

   localparam int          DW     = 32;
   localparam int          AW     = 5;
   localparam int          DEPTH  = 16;
   localparam int          MAXC   = 300;
   localparam logic [31:0] TOHOST = 32'h0000_0FF0;
   localparam int          CW     = $clog2(DEPTH) + 1;
   localparam int          EW     = AW + DW;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          rf_we, d_mem_csn, d_mem_wen, rd_en;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd, d_mem_di;
   logic [31:0]   d_mem_addr;
   logic          rd_valid, overflow, done, pass, fail, timeout;
   logic [EW-1:0] rd_data;
   logic [CW-1:0] count;
   logic [DW-1:0] fail_code;
   logic [31:0]   cycle_cnt;
   logic [1:0]    dbg_state;

   rf_wb_tracer #(
      .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH),
      .TOHOST_ADDR(TOHOST), .MAX_CYCLES(MAXC)
   ) dut (
      .CLK(clk), .RSTn(rst_n),
      .RF_WE(rf_we), .RF_WA(rf_wa), .RF_WD(rf_wd),
      .D_MEM_CSN(d_mem_csn), .D_MEM_WEN(d_mem_wen),
      .D_MEM_ADDR(d_mem_addr), .D_MEM_DI(d_mem_di),
      .RD_EN(rd_en), .RD_VALID(rd_valid), .RD_DATA(rd_data),
      .COUNT(count), .OVERFLOW(overflow), .DONE(done), .PASS(pass),
      .FAIL(fail), .TIMEOUT(timeout), .FAIL_CODE(fail_code),
      .CYCLE_CNT(cycle_cnt), .DBG_STATE(dbg_state)
   );

   // scoreboard / model state
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   bit            m_run, m_pass, m_fail, m_to, m_ovf, m_rv;
   logic [EW-1:0] m_rd;
   logic [31:0]   m_cyc;
   logic [DW-1:0] m_fcode;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_run = 1; m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0; m_rv = 0;
      m_rd = '0; m_cyc = 0; m_fcode = 0;
   endtask

   // One clock edge of behaviour, from the current input values.
   task automatic model_edge();
      bit tohost;
      bit was_run;
      if (rd_en && exp_q.size() > 0) begin
         m_rd = exp_q.pop_front();
         m_rv = 1;
      end else begin
         m_rv = 0;
      end
      if (m_run && rf_we && rf_wa != 0) begin
         if (exp_q.size() < DEPTH) exp_q.push_back({rf_wa, rf_wd});
         else m_ovf = 1;
      end
      was_run = m_run;
      tohost = !d_mem_csn && !d_mem_wen && d_mem_addr == TOHOST;
      if (m_run) begin
         if (tohost) begin
            if (d_mem_di == 1) m_pass = 1;
            else begin
               m_fail = 1;
               m_fcode = d_mem_di / 2;
            end
         end else if (m_cyc == MAXC - 1) begin
            m_to = 1;
         end
      end
      if (was_run && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      m_run = !(m_pass || m_fail || m_to);
   endtask

   task automatic compare_all();
      check_eq("count", count, exp_q.size());
      check_eq("overflow", overflow, m_ovf);
      check_eq("done", done, !m_run);
      check_eq("pass", pass, m_pass);
      check_eq("fail", fail, m_fail);
      check_eq("timeout", timeout, m_to);
      check_eq("fail_code", fail_code, m_fcode);
      check_eq("cycle_cnt", cycle_cnt, m_cyc);
      check_eq("rd_valid", rd_valid, m_rv);
      if (m_rv) check_eq("rd_data", rd_data, m_rd);
   endtask

   // driver tasks
   task automatic set_idle();
      rf_we = 0; rf_wa = 0; rf_wd = 0; rd_en = 0;
      d_mem_csn = 1; d_mem_wen = 1; d_mem_addr = 0; d_mem_di = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic drive_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      rf_we = 1; rf_wa = wa; rf_wd = wd;
   endtask

   task automatic drive_store(input logic [31:0] addr, input logic [DW-1:0] di, input logic is_load);
      d_mem_csn = 0; d_mem_wen = is_load; d_mem_addr = addr; d_mem_di = di;
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      #2;
      rst_n = 0;
      #1;
      check_eq("rst_count", count, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_pass", pass, 0);
      check_eq("rst_fail", fail, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_fail_code", fail_code, 0);
      check_eq("rst_cycle_cnt", cycle_cnt, 0);
      check_eq("rst_rd_valid", rd_valid, 0);
      check_eq("rst_rd_data", rd_data, 0);
      model_reset();
      set_idle();
      @(negedge clk);
      rst_n = 1;
   endtask

   logic [EW-1:0] first_entry;
   logic [31:0]   frozen_cyc;

   initial begin
      set_idle();
      model_reset();
      do_reset();

      // Basic capture, x0 filtered, drain and empty pop.
      drive_write(1, 32'h11); tick();
      drive_write(0, 32'hFF); tick();
      drive_write(2, 32'h22); tick();
      set_idle();
      check_eq("t1_count", count, 2);
      rd_en = 1; tick();
      check_eq("t1_pop1", rd_data, {5'd1, 32'h11});
      tick();
      check_eq("t1_pop2", rd_data, {5'd2, 32'h22});
      tick();
      check_eq("t1_pop3_valid", rd_valid, 0);
      set_idle();

      // Overflow and push+pop at full.
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive_write(AW'(i % 31 + 1), $urandom);
         if (i == 0) first_entry = {rf_wa, rf_wd};
         tick();
      end
      check_eq("t2_count_full", count, DEPTH);
      check_eq("t2_overflow", overflow, 1);
      drive_write(7, 32'hCAFE_0007); rd_en = 1; tick();
      check_eq("t2_pushpop_count", count, DEPTH);
      check_eq("t2_pushpop_data", rd_data, first_entry);
      set_idle(); rd_en = 1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      set_idle();

      // Load of tohost ignored; store of 1 passes; later writes dropped.
      do_reset();
      for (int i = 0; i < 3; i++) begin drive_write(AW'(i + 3), $urandom); tick(); end
      set_idle(); drive_store(TOHOST, 32'h7, 1'b1); tick();
      check_eq("t3_load_no_done", done, 0);
      set_idle(); drive_store(TOHOST, 32'h1, 1'b0); drive_write(9, 32'h99); tick();
      check_eq("t3_pass", pass, 1);
      check_eq("t3_same_cycle_write", count, 4);
      frozen_cyc = cycle_cnt;
      set_idle();
      for (int i = 0; i < 3; i++) begin drive_write(10, $urandom); tick(); end
      check_eq("t3_cyc_frozen", cycle_cnt, frozen_cyc);
      set_idle(); rd_en = 1;
      for (int i = 0; i < 5; i++) tick();
      set_idle();

      // Store of 7 fails with code 3.
      do_reset();
      drive_store(TOHOST, 32'h7, 1'b0); tick();
      check_eq("t4_fail", fail, 1);
      check_eq("t4_fail_code", fail_code, 3);
      set_idle(); tick();

      // Timeout exactly at edge MAXC.
      do_reset();
      for (int i = 0; i < MAXC - 1; i++) tick();
      check_eq("t5_not_yet", done, 0);
      tick();
      check_eq("t5_timeout", timeout, 1);
      check_eq("t5_cyc", cycle_cnt, MAXC);
      tick(); tick();

      // Tohost store on the timeout edge wins.
      do_reset();
      for (int i = 0; i < MAXC - 1; i++) tick();
      drive_store(TOHOST, 32'h1, 1'b0); tick();
      check_eq("t5b_pass", pass, 1);
      check_eq("t5b_no_timeout", timeout, 0);
      set_idle(); tick();

      // Mid-run async reset with entries and verdict held.
      do_reset();
      for (int i = 0; i < 5; i++) begin drive_write(AW'(i + 1), $urandom); tick(); end
      set_idle(); drive_store(TOHOST, 32'h1, 1'b0); tick();
      check_eq("t6_count5", count, 5);
      check_eq("t6_pass", pass, 1);
      do_reset();

      // Randomized traffic.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            rf_we = 1'($urandom_range(0, 1));
            rf_wa = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
            rf_wd = $urandom;
            rd_en = (c < 75) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            d_mem_csn = 1'($urandom_range(0, 1));
            d_mem_wen = 1'($urandom_range(0, 1));
            d_mem_addr = ($urandom_range(0, 19) == 0) ? TOHOST : ($urandom & 32'hFFFF_0FFC) | 32'h1000;
            d_mem_di = $urandom_range(0, 3);
            tick();
         end
         set_idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
